pipe_collision_ctrl: RTL and testbench

- Consumes the bird's vertical position from the bird physics stage.
- Scrolls a single pipe obstacle across the screen, randomises its gap, detects bird/pipe/ground/ceiling collisions and keeps a two-digit BCD score.
- Owns the game state machine (IDLE/PLAY/DEAD) and issues the reset pulse that re-arms the physics stage at game start.

---
 rtl/pipe_collision_if.sv | 23 ++
 rtl/pipe_collision_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_collision_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_collision_if.sv
// Bundles the game-control signals between the bird/front-end side and the collision controller.
// The controller drives pipe position, gap, score and game state; the master drives strobes and bird_y.
interface pipe_collision_if;
    logic              tick;
    logic              start;
    logic signed [8:0] bird_y;
    logic signed [10:0] pipe_x;
    logic [8:0]        gap_y;
    logic [7:0]        score;
    logic [1:0]        state;
    logic              bird_rst;
    logic              playing;

    modport master (
        output tick, start, bird_y,
        input  pipe_x, gap_y, score, state, bird_rst, playing
    );

    modport slave (
        input  tick, start, bird_y,
        output pipe_x, gap_y, score, state, bird_rst, playing
    );
endinterface

// File: rtl/pipe_collision_ctrl.sv
// Single-pipe obstacle scroller with collision detection, BCD scoring and the IDLE/PLAY/DEAD
// game FSM; pulses bird_rst to re-arm the physics stage when a game starts.
module pipe_collision_ctrl #(
    parameter int          BIRD_X    = 160,
    parameter int          BIRD_W    = 16,
    parameter int          BIRD_H    = 16,
    parameter int          PIPE_W    = 40,
    parameter int          GAP_H     = 120,
    parameter int          GAP_MIN   = 40,
    parameter int          SCROLL    = 2,
    parameter int          SCREEN_W  = 640,
    parameter int          Y_TOP     = 480,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input logic            clk,
    input logic            rst,
    pipe_collision_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StPlay = 2'b01,
        StDead = 2'b10
    } state_e;

    localparam logic signed [11:0] BirdXL   = 12'(BIRD_X);
    localparam logic signed [11:0] BirdXR   = 12'(BIRD_X + BIRD_W);
    localparam logic signed [11:0] PipeW    = 12'(PIPE_W);
    localparam logic signed [11:0] NegPipeW = 12'(-PIPE_W);
    localparam logic signed [11:0] Scroll   = 12'(SCROLL);
    localparam logic signed [10:0] ScreenW  = 11'(SCREEN_W);
    localparam logic signed [10:0] BirdH    = 11'(BIRD_H);
    localparam logic signed [10:0] YTop     = 11'(Y_TOP);
    localparam logic signed [10:0] GapH     = 11'(GAP_H);
    localparam logic [8:0]         GapMin   = 9'(GAP_MIN);

    state_e             state_q, state_d;
    logic signed [10:0] pipe_x_q, pipe_x_d;
    logic [8:0]         gap_q, gap_d;
    logic [7:0]         score_q, score_d;
    logic               scored_q, scored_d;
    logic               bird_rst_q, bird_rst_d;
    logic [7:0]         lfsr_q, lfsr_d;

    logic signed [11:0] px, x_mv;
    logic signed [10:0] by, gy;
    logic               hit_ground, hit_ceil, overlap, hit_pipe, hit_any;
    logic               respawn, crossed;
    logic [8:0]         gap_new;

    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        logic [3:0] tens;
        if (s[3:0] == 4'd9) begin
            tens = (s[7:4] == 4'd9) ? 4'd0 : s[7:4] + 4'd1;
            return {tens, 4'd0};
        end
        return {s[7:4], s[3:0] + 4'd1};
    endfunction

    // x math in 12-bit signed, y math in 11-bit signed so negative positions compare correctly
    assign px   = {pipe_x_q[10], pipe_x_q};
    assign x_mv = px - Scroll;
    assign by   = {{2{bus.bird_y[8]}}, bus.bird_y};
    assign gy   = {2'b00, gap_q};

    assign hit_ground = (by <= 11'sd0);
    assign hit_ceil   = ((by + BirdH) >= YTop);
    assign overlap    = (px < BirdXR) && ((px + PipeW) > BirdXL);
    assign hit_pipe   = overlap && ((by < gy) || ((by + BirdH) > (gy + GapH)));
    assign hit_any    = hit_ground || hit_ceil || hit_pipe;
    assign respawn    = (x_mv <= NegPipeW);
    assign crossed    = ((x_mv + PipeW) <= BirdXL);
    assign gap_new    = GapMin + {1'b0, lfsr_q};

    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        state_d    = state_q;
        pipe_x_d   = pipe_x_q;
        gap_d      = gap_q;
        score_d    = score_q;
        scored_d   = scored_q;
        bird_rst_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d    = StPlay;
                    bird_rst_d = 1'b1;
                    pipe_x_d   = ScreenW;
                    gap_d      = gap_new;
                    score_d    = 8'h00;
                    scored_d   = 1'b0;
                end
            end
            StPlay: begin
                if (bus.tick) begin
                    if (hit_any) begin
                        state_d = StDead;
                    end else if (respawn) begin
                        pipe_x_d = ScreenW;
                        gap_d    = gap_new;
                        scored_d = 1'b0;
                    end else begin
                        pipe_x_d = x_mv[10:0];
                        if (!scored_q && crossed) begin
                            score_d  = bcd_inc(score_q);
                            scored_d = 1'b1;
                        end
                    end
                end
            end
            StDead: begin
                if (bus.start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            pipe_x_q   <= ScreenW;
            gap_q      <= GapMin + {1'b0, LFSR_SEED};
            score_q    <= 8'h00;
            scored_q   <= 1'b0;
            bird_rst_q <= 1'b0;
            lfsr_q     <= LFSR_SEED;
        end else begin
            state_q    <= state_d;
            pipe_x_q   <= pipe_x_d;
            gap_q      <= gap_d;
            score_q    <= score_d;
            scored_q   <= scored_d;
            bird_rst_q <= bird_rst_d;
            lfsr_q     <= lfsr_d;
        end
    end

    assign bus.pipe_x   = pipe_x_q;
    assign bus.gap_y    = gap_q;
    assign bus.score    = score_q;
    assign bus.state    = state_q;
    assign bus.bird_rst = bird_rst_q;
    assign bus.playing  = (state_q == StPlay);

endmodule

// File: tb/tb_pipe_collision_ctrl.sv
// Directed bench for pipe_collision_ctrl: reset, scrolling, scoring, collisions, BCD wrap, reset.
// Stimulus is timed against a reference LFSR so that pipe gaps are known in advance.
module tb_pipe_collision_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   exp_x;
    int   g;
    logic [7:0] m_lfsr;

    pipe_collision_if bus ();

    pipe_collision_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference x^8+x^6+x^5+x^4+1 sequence, used to know which gap the next load will pick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do_tick();
            exp_x -= 2;
        end
    endtask

    // Wait until the next load yields gap 205 (seed) or a gap low enough for bird_y to fit
    task automatic wait_lfsr(input bit want_seed, output int gap);
        for (int i = 0; i < 300; i++) begin
            if (want_seed ? (m_lfsr == 8'hA5) : (m_lfsr <= 8'd160)) break;
            cyc();
        end
        if (want_seed) check("lfsr_wait_seed", int'(m_lfsr), 'hA5);
        else           check("lfsr_wait_low", int'(m_lfsr <= 8'd160), 1);
        gap = 40 + int'(m_lfsr);
    endtask

    task automatic start_game(input bit want_seed);
        int gl;
        wait_lfsr(want_seed, gl);
        g            = gl;
        bus.bird_y   = 9'(gl + 35);
        bus.start    = 1'b1;
        bus.tick     = 1'b1;
        cyc();
        bus.start    = 1'b0;
        bus.tick     = 1'b0;
        exp_x        = 640;
        check("start_bird_rst", int'(bus.bird_rst), 1);
        check("start_state", int'(bus.state), 1);
        check("start_pipe_x", int'(bus.pipe_x), 640);
        check("start_gap_y", int'(bus.gap_y), gl);
        check("start_score", int'(bus.score), 0);
        cyc();
        check("bird_rst_one_cycle", int'(bus.bird_rst), 0);
    endtask

    task automatic run_to_respawn();
        int gl;
        while (exp_x - 2 > -40) begin
            do_tick();
            exp_x -= 2;
        end
        wait_lfsr(1'b0, gl);
        g = gl;
        do_tick();
        exp_x      = 640;
        bus.bird_y = 9'(gl + 35);
        check("respawn_pipe_x", int'(bus.pipe_x), 640);
        check("respawn_gap_y", int'(bus.gap_y), gl);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        bus.tick   = 1'b0;
        bus.start  = 1'b0;
        bus.bird_y = 9'sd0;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1. reset state; ticks in IDLE do nothing
        check("rst_state", int'(bus.state), 0);
        check("rst_pipe_x", int'(bus.pipe_x), 640);
        check("rst_gap_y", int'(bus.gap_y), 205);
        check("rst_score", int'(bus.score), 0);
        check("rst_bird_rst", int'(bus.bird_rst), 0);
        check("rst_playing", int'(bus.playing), 0);
        do_tick();
        do_tick();
        check("idle_tick_ignored", int'(bus.pipe_x), 640);

        // 2. start with gap 205, bird at 240; start during PLAY is ignored
        start_game(1'b1);
        check("play_bird_y_gap", g, 205);
        check("playing_high", int'(bus.playing), 1);
        bus.start = 1'b1;
        ticks(1);
        bus.start = 1'b0;
        check("start_in_play_state", int'(bus.state), 1);
        check("start_in_play_no_rst", int'(bus.bird_rst), 0);
        ticks(9);
        check("ten_ticks_pipe_x", int'(bus.pipe_x), 620);
        check("ten_ticks_state", int'(bus.state), 1);

        // 3. score on the crossing tick, then respawn keeps the score
        ticks(249);
        check("pre_cross_pipe_x", int'(bus.pipe_x), 122);
        check("pre_cross_score", int'(bus.score), 0);
        ticks(1);
        check("cross_score", int'(bus.score), 'h01);
        ticks(5);
        check("score_once", int'(bus.score), 'h01);
        run_to_respawn();
        check("respawn_score", int'(bus.score), 'h01);

        // 4. ground hit, DEAD holds, start -> IDLE (no bird_rst) -> PLAY
        bus.bird_y = 9'sd0;
        do_tick();
        check("ground_state", int'(bus.state), 2);
        check("ground_playing", int'(bus.playing), 0);
        ticks(4);
        check("dead_pipe_x", int'(bus.pipe_x), 640);
        check("dead_score", int'(bus.score), 'h01);
        bus.start = 1'b1;
        bus.tick  = 1'b1;
        cyc();
        bus.start = 1'b0;
        bus.tick  = 1'b0;
        check("dead_start_state", int'(bus.state), 0);
        check("dead_start_no_rst", int'(bus.bird_rst), 0);

        // 5a. pipe collision at pipe_x=150
        start_game(1'b1);
        ticks(245);
        check("pipe150_pos", int'(bus.pipe_x), 150);
        bus.bird_y = 9'sd100;
        do_tick();
        check("pipe150_state", int'(bus.state), 2);
        check("pipe150_frozen", int'(bus.pipe_x), 150);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;

        // 5b. hit on the same tick that would have scored
        start_game(1'b1);
        ticks(259);
        bus.bird_y = 9'sd100;
        do_tick();
        check("cross_hit_state", int'(bus.state), 2);
        check("cross_hit_pipe_x", int'(bus.pipe_x), 122);
        check("cross_hit_score", int'(bus.score), 0);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;

        // 6. BCD carry 09->10 and wrap 99->00 over 100 pipe passes
        start_game(1'b0);
        for (int p = 1; p <= 100; p++) begin
            run_to_respawn();
            if (p == 9)   check("score_09", int'(bus.score), 'h09);
            if (p == 10)  check("score_10", int'(bus.score), 'h10);
            if (p == 99)  check("score_99", int'(bus.score), 'h99);
            if (p == 100) check("score_wrap_00", int'(bus.score), 'h00);
        end
        check("long_game_state", int'(bus.state), 1);

        // asynchronous reset mid-PLAY takes effect without a clock edge
        ticks(30);
        rst = 1'b1;
        #1;
        check("async_rst_state", int'(bus.state), 0);
        check("async_rst_pipe_x", int'(bus.pipe_x), 640);
        check("async_rst_gap_y", int'(bus.gap_y), 205);
        check("async_rst_score", int'(bus.score), 0);
        check("async_rst_bird_rst", int'(bus.bird_rst), 0);
        cyc();
        rst = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
